regfile_sb: RTL

Parametrised multi-port register file with an integrated scoreboard. It is the successor to the fixed 32x32 2R1W register file in the MIPS32 SoC core. It adds a configurable number of read ports, two prioritised write ports, optional write-to-read bypass, an optional hardwired zero register and per-register busy bits. The busy bits let the decode stage detect RAW hazards on pending writebacks (e.g. multi-cycle loads). It sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_scoreboard.sv | 41 ++++
 rtl/regfile_sb.sv | 124 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int DW_DEF    = 32;
    localparam int DEPTH_DEF = 32;
    localparam int AW_DEF    = 5;
    localparam int NR_DEF    = 2;

    localparam logic [DW_DEF-1:0] ZERO_WORD = {DW_DEF{1'b0}};

    // Smallest w with 2^w >= value, used to check that AW can reach DEPTH.
    function automatic int clog2_f(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with set-over-clear priority and duplicate-set pulse.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEPTH-1:0] set_vec,
    input  logic [DEPTH-1:0] clr_vec,
    output logic [DEPTH-1:0] busy,
    output logic             sb_dup
);

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] busy_next_s;
    logic             dup_r;
    logic             dup_s;

    // Next busy state: completing writebacks clear, a new producer then re-sets
    // (the new producer supersedes the one finishing on the same edge).
    always_comb begin
        busy_next_s = (busy_r & ~clr_vec) | set_vec;
        dup_s       = |(set_vec & busy_r & ~clr_vec);
    end

    // Busy flops and the one-cycle duplicate-set pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {DEPTH{1'b0}};
            dup_r  <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            dup_r  <= dup_s;
        end
    end

    assign busy   = busy_r;
    assign sb_dup = dup_r;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with two prioritised write ports, optional
// write-to-read bypass, optional hardwired zero register and a scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AW       = AW_DEF,
    parameter int NR       = NR_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NR*AW-1:0] ra,
    output logic [NR*DW-1:0] rd,
    output logic [NR-1:0]    rbusy,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic [DW-1:0]    wd0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [DW-1:0]    wd1,
    input  logic             sb_set,
    input  logic [AW-1:0]    sb_addr,
    output logic             sb_dup
);

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [DW-1:0] ZERO_DW = DW'(ZERO_WORD);
    localparam logic [AW-1:0] ADDR0   = {AW{1'b0}};
    localparam bit            BYP     = (BYPASS != 0);
    localparam bit            ZR      = (ZERO_REG != 0);

    if (clog2_f(DEPTH) > AW) begin : g_aw_check
        $error("regfile_sb: AW too small to address DEPTH registers");
    end

    logic [DW-1:0]    mem_r [DEPTH];
    logic             w0_eff_s;
    logic             w1_eff_s;
    logic             sb_eff_s;
    logic [DEPTH-1:0] set_vec_s;
    logic [DEPTH-1:0] clr_vec_s;
    logic [DEPTH-1:0] busy_s;

    // Qualify writes and scoreboard sets; nothing is effective while in reset
    // so bypass cannot leak data onto rd during reset.
    always_comb begin
        w0_eff_s = rst_n && we0 && ({1'b0, wa0} < DEPTH_W) && !(ZR && (wa0 == ADDR0));
        w1_eff_s = rst_n && we1 && ({1'b0, wa1} < DEPTH_W) && !(ZR && (wa1 == ADDR0));
        sb_eff_s = rst_n && sb_set && ({1'b0, sb_addr} < DEPTH_W) && !(ZR && (sb_addr == ADDR0));
    end

    // Storage array; port 1 is written last so it wins an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_r[k] <= ZERO_DW;
            end
        end else begin
            if (w0_eff_s) begin
                mem_r[wa0] <= wd0;
            end
            if (w1_eff_s) begin
                mem_r[wa1] <= wd1;
            end
        end
    end

    for (genvar j = 0; j < DEPTH; j++) begin : g_vec
        localparam logic [AW-1:0] IDX = AW'(j);
        assign set_vec_s[j] = sb_eff_s && (sb_addr == IDX);
        assign clr_vec_s[j] = (w0_eff_s && (wa0 == IDX)) || (w1_eff_s && (wa1 == IDX));
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_vec (set_vec_s),
        .clr_vec (clr_vec_s),
        .busy    (busy_s),
        .sb_dup  (sb_dup)
    );

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] addr_s;
        logic          in_range_s;
        logic          hit0_s;
        logic          hit1_s;
        logic [DW-1:0] data_s;
        logic          busy_rd_s;

        assign addr_s = ra[i*AW +: AW];

        // Per-port read: range check, zero register, forwarding, then storage.
        always_comb begin
            in_range_s = ({1'b0, addr_s} < DEPTH_W);
            hit0_s     = w0_eff_s && (wa0 == addr_s);
            hit1_s     = w1_eff_s && (wa1 == addr_s);
            if (!in_range_s) begin
                data_s    = ZERO_DW;
                busy_rd_s = 1'b0;
            end else begin
                if (ZR && (addr_s == ADDR0)) begin
                    data_s = ZERO_DW;
                end else if (BYP && hit1_s) begin
                    data_s = wd1;
                end else if (BYP && hit0_s) begin
                    data_s = wd0;
                end else begin
                    data_s = mem_r[addr_s];
                end
                busy_rd_s = busy_s[addr_s] && !(BYP && (hit0_s || hit1_s));
            end
        end

        assign rd[i*DW +: DW] = data_s;
        assign rbusy[i]       = busy_rd_s;
    end

endmodule
